// File: rtl/cpu_mem_responder_pkg.sv
// Shared types for the CPU memory responder: one-hot FSM states, request kinds,
// wait-counter sizing and the address range helper.
package cpu_mem_pkg;

    localparam int LATENCY_MAX = 15;
    localparam int CTR_W       = $clog2(LATENCY_MAX + 1);

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        WAIT    = 5'b00010,
        ACCESS  = 5'b00100,
        CAPTURE = 5'b01000,
        RESP    = 5'b10000
    } state_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } kind_e;

    // Byte address lies inside the 4*2^addr_w byte SRAM window.
    function automatic logic addr_in_range(input logic [31:0] addr, input int addr_w);
        return (addr >> (addr_w + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_wait_ctr.sv
// Load/decrement wait-state counter; done is high whenever the count has reached zero.
module mem_wait_ctr
    import cpu_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CTR_W-1:0] cnt_d, cnt_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/cpu_mem_responder.sv
// Single-port SRAM responder serving CPU fetches, loads and stores one at a time,
// with LATENCY programmable wait states between request accept and SRAM access.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       PC,
    input  logic              Inst_Req_Valid,
    output logic              Inst_Req_Ready,
    output logic [31:0]       Instruction,
    output logic              Inst_Valid,
    input  logic              Inst_Ready,
    input  logic [31:0]       Address,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Write_data,
    input  logic [3:0]        Write_strb,
    output logic              Mem_Req_Ready,
    output logic [31:0]       Read_data,
    output logic              Read_data_Valid,
    input  logic              Read_data_Ready,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              addr_err
);

    localparam logic [CTR_W-1:0] WAIT_LOAD = (LATENCY == 0) ? '0 : CTR_W'(LATENCY - 1);

    state_e            state_d, state_q;
    kind_e             kind_d, kind_q;
    logic [ADDR_W-1:0] waddr_d, waddr_q;
    logic [31:0]       wdata_d, wdata_q;
    logic [3:0]        strb_d, strb_q;
    logic              oor_d, oor_q;
    logic [31:0]       rdata_d, rdata_q;
    logic              err_d, err_q;

    logic              data_req;
    logic [31:0]       req_addr;
    logic              ctr_load, ctr_dec, ctr_done;

    mem_wait_ctr u_wait_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ctr_load),
        .load_val (WAIT_LOAD),
        .dec      (ctr_dec),
        .done     (ctr_done)
    );

    always_comb begin
        state_d         = state_q;
        kind_d          = kind_q;
        waddr_d         = waddr_q;
        wdata_d         = wdata_q;
        strb_d          = strb_q;
        oor_d           = oor_q;
        rdata_d         = rdata_q;
        err_d           = err_q;
        ctr_load        = 1'b0;
        ctr_dec         = 1'b0;
        Inst_Req_Ready  = 1'b0;
        Mem_Req_Ready   = 1'b0;
        sram_en         = 1'b0;
        sram_wen        = 4'b0000;
        Inst_Valid      = 1'b0;
        Read_data_Valid = 1'b0;
        data_req        = MemRead | MemWrite;
        req_addr        = data_req ? Address : PC;

        case (state_q)
            IDLE: begin
                // Readies are combinational; gating with rst_n keeps them low while reset is held.
                Mem_Req_Ready  = rst_n & data_req;
                Inst_Req_Ready = rst_n & Inst_Req_Valid & ~data_req;
                if (data_req || Inst_Req_Valid) begin
                    kind_d   = MemWrite ? STORE : (MemRead ? LOAD : FETCH);
                    waddr_d  = req_addr[ADDR_W+1:2];
                    wdata_d  = Write_data;
                    strb_d   = Write_strb;
                    oor_d    = ~addr_in_range(req_addr, ADDR_W);
                    ctr_load = 1'b1;
                    state_d  = (LATENCY > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (ctr_done) begin
                    state_d = ACCESS;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ACCESS: begin
                if (oor_q) begin
                    err_d = 1'b1;
                end else begin
                    sram_en  = 1'b1;
                    sram_wen = (kind_q == STORE) ? strb_q : 4'b0000;
                end
                state_d = (kind_q == STORE) ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                rdata_d = oor_q ? 32'h0 : sram_rdata;
                state_d = RESP;
            end
            RESP: begin
                Inst_Valid      = (kind_q == FETCH);
                Read_data_Valid = (kind_q == LOAD);
                if ((kind_q == FETCH && Inst_Ready) || (kind_q == LOAD && Read_data_Ready)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            kind_q  <= FETCH;
            waddr_q <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign Instruction = rdata_q;
    assign Read_data   = rdata_q;
    assign sram_addr   = waddr_q;
    assign sram_wdata  = wdata_q;
    assign addr_err    = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized bench for cpu_mem_responder: behavioural SRAM plus a word-array reference
// model of memory contents, response timing and the sticky error flag.
module tb_cpu_mem_responder;

    localparam int ADDR_W  = 12;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       PC = '0;
    logic              Inst_Req_Valid = 1'b0;
    logic              Inst_Req_Ready;
    logic [31:0]       Instruction;
    logic              Inst_Valid;
    logic              Inst_Ready = 1'b0;
    logic [31:0]       Address = '0;
    logic              MemRead = 1'b0;
    logic              MemWrite = 1'b0;
    logic [31:0]       Write_data = '0;
    logic [3:0]        Write_strb = '0;
    logic              Mem_Req_Ready;
    logic [31:0]       Read_data;
    logic              Read_data_Valid;
    logic              Read_data_Ready = 1'b0;
    logic              sram_en;
    logic [3:0]        sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata = '0;
    logic              addr_err;

    cpu_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .PC              (PC),
        .Inst_Req_Valid  (Inst_Req_Valid),
        .Inst_Req_Ready  (Inst_Req_Ready),
        .Instruction     (Instruction),
        .Inst_Valid      (Inst_Valid),
        .Inst_Ready      (Inst_Ready),
        .Address         (Address),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .Write_data      (Write_data),
        .Write_strb      (Write_strb),
        .Mem_Req_Ready   (Mem_Req_Ready),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ready (Read_data_Ready),
        .sram_en         (sram_en),
        .sram_wen        (sram_wen),
        .sram_addr       (sram_addr),
        .sram_wdata      (sram_wdata),
        .sram_rdata      (sram_rdata),
        .addr_err        (addr_err)
    );

    always #5 clk = ~clk;

    // Behavioural 1-cycle synchronous-read SRAM with access bookkeeping.
    logic [31:0]       sram_mem [DEPTH];
    logic [31:0]       ref_mem  [DEPTH];
    int                en_count = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    always @(posedge clk) begin
        if (sram_en) begin
            en_count  <= en_count + 1;
            last_addr <= sram_addr;
            if (sram_wen == 4'b0000) begin
                sram_rdata <= sram_mem[sram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wen[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;
    logic exp_err = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] outs_bundle();
        return {Inst_Req_Ready, Mem_Req_Ready, Inst_Valid, Read_data_Valid, sram_en, sram_wen,
                addr_err, Instruction, Read_data, sram_addr, sram_wdata};
    endfunction

    function automatic bit in_range(input logic [31:0] addr);
        return addr < 32'(4 * DEPTH);
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    // kind: 0 fetch, 1 load, 2 store, 3 MemRead+MemWrite (a store).
    // Called just after a rising edge; returns just after a rising edge with the DUT idle.
    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int hold,
                           input bit fetch_pending, input logic [31:0] pend_pc);
        bit          ok = in_range(addr);
        int          w = word_of(addr);
        int          en0;
        int          cyc;
        logic        valid;
        logic [31:0] exp_data;

        case (kind)
            0: begin Inst_Req_Valid = 1'b1; PC = addr; end
            1: begin MemRead = 1'b1; Address = addr; end
            2: begin MemWrite = 1'b1; Address = addr; end
            default: begin MemRead = 1'b1; MemWrite = 1'b1; Address = addr; end
        endcase
        Write_data = wdata;
        Write_strb = strb;
        if (fetch_pending) begin
            Inst_Req_Valid = 1'b1;
            PC = pend_pc;
        end
        #1;
        check("mem_req_ready", Mem_Req_Ready, kind != 0);
        check("inst_req_ready", Inst_Req_Ready, kind == 0);
        en0 = en_count;
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        if (!fetch_pending) Inst_Req_Valid = 1'b0;
        check("readies_busy", {Mem_Req_Ready, Inst_Req_Ready}, 2'b00);

        if (kind >= 2) begin
            repeat (LATENCY) @(posedge clk);
            #1;
            check("store_en", sram_en, ok);
            check("store_wen", sram_wen, ok ? strb : 4'b0000);
            if (ok) check("store_addr", sram_addr, w);
            @(posedge clk);
            #1;
            check("store_count", en_count - en0, ok ? 1 : 0);
            if (ok) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                exp_err = 1'b1;
            end
        end else begin
            exp_data = ok ? ref_mem[w] : 32'h0;
            if (hold == 0) begin
                if (kind == 0) Inst_Ready = 1'b1;
                else Read_data_Ready = 1'b1;
            end
            cyc = 0;
            valid = 1'b0;
            while (!valid && cyc < 50) begin
                @(posedge clk);
                #1;
                cyc++;
                valid = (kind == 0) ? Inst_Valid : Read_data_Valid;
            end
            check("resp_latency", cyc, LATENCY + 2);
            check("resp_data", (kind == 0) ? Instruction : Read_data, exp_data);
            check("other_valid", (kind == 0) ? Read_data_Valid : Inst_Valid, 1'b0);
            check("read_count", en_count - en0, ok ? 1 : 0);
            if (ok) check("read_addr", last_addr, w);
            else exp_err = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                check("resp_hold",
                      {(kind == 0) ? Inst_Valid : Read_data_Valid,
                       (kind == 0) ? Instruction : Read_data, Mem_Req_Ready, Inst_Req_Ready},
                      {1'b1, exp_data, 2'b00});
            end
            if (kind == 0) Inst_Ready = 1'b1;
            else Read_data_Ready = 1'b1;
            @(posedge clk);
            #1;
            Inst_Ready = 1'b0;
            Read_data_Ready = 1'b0;
            check("resp_done", {Inst_Valid, Read_data_Valid}, 2'b00);
        end
        check("addr_err", addr_err, exp_err);
        if (fetch_pending) check("pending_fetch_ready", Inst_Req_Ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          en0;
        logic [31:0] a;

        for (int i = 0; i < DEPTH; i++) begin
            a = $urandom();
            sram_mem[i] = a;
            ref_mem[i]  = a;
        end
        sram_mem[2] = 32'h0050_0093; ref_mem[2] = 32'h0050_0093;
        sram_mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs_bundle(), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fetch of a known instruction, held three cycles before consumption.
        run_txn(0, 32'h8, '0, '0, 3, 1'b0, '0);
        // Byte-lane store into a known word, then read it back.
        run_txn(2, 32'h11, 32'h0000_AB00, 4'b0010, 0, 1'b0, '0);
        run_txn(1, 32'h10, '0, '0, 1, 1'b0, '0);
        check("merged_word", ref_mem[4], 32'h1122_AB44);
        // Load and fetch together: load first, fetch in the following idle cycle.
        run_txn(1, 32'h40, '0, '0, 2, 1'b1, 32'h8);
        run_txn(0, 32'h8, '0, '0, 0, 1'b0, '0);
        // Long back-pressure on a load response.
        run_txn(1, 32'h24, '0, '0, 5, 1'b0, '0);

        // Reset during the wait phase of a store: no write may reach the SRAM.
        MemWrite = 1'b1;
        Address = 32'h20;
        Write_data = 32'hDEAD_BEEF;
        Write_strb = 4'hF;
        #1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        en0 = en_count;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs_bundle(), '0);
        repeat (4) @(posedge clk);
        #1;
        check("reset_no_access", en_count - en0, 0);
        rst_n = 1'b1;
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        run_txn(1, 32'h20, '0, '0, 0, 1'b0, '0);

        // Out-of-range load returns zero and sets the sticky error.
        run_txn(1, 32'h0010_0000, '0, '0, 1, 1'b0, '0);
        run_txn(0, 32'h4, '0, '0, 0, 1'b0, '0);

        for (int n = 0; n < 60; n++) begin
            int          k;
            logic [31:0] addr;
            k = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = $urandom() | 32'h8000_0000;
            else if ($urandom_range(0, 3) == 0) addr = 32'(4 * DEPTH) + $urandom_range(0, 3);
            else addr = $urandom_range(0, 4 * DEPTH - 1);
            run_txn(k, addr, $urandom(), 4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                    1'b0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
